fetch_arbiter: RTL and testbench

//  Owns the single 128-bit external-memory read port and shares it between the feature fetch

---
 rtl/fetch_arbiter.sv | 126 ++++++++++++
 tb/tb_fetch_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_arbiter.sv
// Shares one external 128-bit read port between the feature and weight fetch units.
// Round-robin burst grant, pipelined word reads capped at MAX_OUT in flight, registered data return.
module fetch_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 128,
  parameter int LEN_W   = 8,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              feat_req,
  input  logic [ADDR_W-1:0] feat_src_addr,
  input  logic [LEN_W-1:0]  feat_len,
  output logic              feat_ack,
  output logic              feat_done,
  input  logic              wt_req,
  input  logic [ADDR_W-1:0] wt_src_addr,
  input  logic [LEN_W-1:0]  wt_len,
  output logic              wt_ack,
  output logic              wt_done,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_ready,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] fetch_data,
  output logic              feature_fetch_enable,
  output logic              weight_fetch_enable,
  output logic              busy,
  output logic              protocol_err
);
  localparam int CNT_W = LEN_W + 1;
  localparam int OUT_W = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t            state;
  logic              owner_wt, last_wt;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  len_q, issued, received;
  logic [OUT_W-1:0]  outstanding;
  logic              grant_feat, grant_wt, accept, beat;
  logic [LEN_W-1:0]  req_len;
  logic [ADDR_W-1:0] req_addr;

  // last_wt=1 means the feature unit wins the next contested grant
  assign grant_feat = rst && (state == IDLE) && feat_req && (!wt_req || last_wt);
  assign grant_wt   = rst && (state == IDLE) && wt_req && (!feat_req || !last_wt);
  assign feat_ack   = grant_feat;
  assign wt_ack     = grant_wt;
  assign req_len    = grant_wt ? wt_len : feat_len;
  assign req_addr   = grant_wt ? wt_src_addr : feat_src_addr;

  assign busy        = (state != IDLE);
  assign mem_rd_req  = (state == ISSUE) && (issued < len_q) && (outstanding < OUT_W'(MAX_OUT));
  assign mem_rd_addr = base + ADDR_W'(issued);
  assign accept      = mem_rd_req && mem_rd_ready;
  // returns with nothing outstanding are dropped and flagged
  assign beat        = mem_rd_valid && (outstanding != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= IDLE;
      owner_wt             <= 1'b0;
      last_wt              <= 1'b1;
      base                 <= '0;
      len_q                <= '0;
      issued               <= '0;
      received             <= '0;
      outstanding          <= '0;
      feat_done            <= 1'b0;
      wt_done              <= 1'b0;
      fetch_data           <= '0;
      feature_fetch_enable <= 1'b0;
      weight_fetch_enable  <= 1'b0;
      protocol_err         <= 1'b0;
    end else begin
      feat_done            <= 1'b0;
      wt_done              <= 1'b0;
      feature_fetch_enable <= 1'b0;
      weight_fetch_enable  <= 1'b0;
      if (mem_rd_valid && (outstanding == '0)) protocol_err <= 1'b1;

      if (accept && !beat)      outstanding <= outstanding + OUT_W'(1);
      else if (beat && !accept) outstanding <= outstanding - OUT_W'(1);
      if (accept) issued <= issued + CNT_W'(1);

      if (beat) begin
        fetch_data           <= mem_rd_data;
        feature_fetch_enable <= !owner_wt;
        weight_fetch_enable  <= owner_wt;
        received             <= received + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (grant_feat || grant_wt) begin
            owner_wt <= grant_wt;
            base     <= req_addr;
            len_q    <= CNT_W'(req_len);
            issued   <= '0;
            received <= '0;
            state    <= (req_len == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          // done rides with the last enable beat
          if (beat && (received + CNT_W'(1) == len_q)) begin
            feat_done <= !owner_wt;
            wt_done   <= owner_wt;
            state     <= DONE;
          end
        end
        DONE: begin
          last_wt <= owner_wt;
          state   <= IDLE;
          if (len_q == '0) begin
            feat_done <= !owner_wt;
            wt_done   <= owner_wt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_arbiter.sv
// Bench for fetch_arbiter: random bursts from both units against a queue-based memory and
// burst-level reference; a negedge monitor scores every DUT output against the expected stream.
module tb_fetch_arbiter;
  localparam int MAX_OUT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         feat_req, wt_req;
  logic [15:0]  feat_src_addr, wt_src_addr;
  logic [7:0]   feat_len, wt_len;
  logic         feat_ack, feat_done, wt_ack, wt_done;
  logic         mem_rd_req, mem_rd_ready, mem_rd_valid;
  logic [15:0]  mem_rd_addr;
  logic [127:0] mem_rd_data, fetch_data;
  logic         feature_fetch_enable, weight_fetch_enable, busy, protocol_err;

  fetch_arbiter #(.ADDR_W(16), .DATA_W(128), .LEN_W(8), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .feat_req(feat_req), .feat_src_addr(feat_src_addr), .feat_len(feat_len),
    .feat_ack(feat_ack), .feat_done(feat_done),
    .wt_req(wt_req), .wt_src_addr(wt_src_addr), .wt_len(wt_len),
    .wt_ack(wt_ack), .wt_done(wt_done),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ready(mem_rd_ready),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .fetch_data(fetch_data), .feature_fetch_enable(feature_fetch_enable),
    .weight_fetch_enable(weight_fetch_enable), .busy(busy), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct { bit wt; logic [127:0] data; bit last; } beat_t;
  typedef struct { logic [15:0] addr; int rdy; } pend_t;

  beat_t       exp_q[$];
  logic [15:0] exp_addr_q[$];
  pend_t       pend[$];

  int checks = 0, errors = 0;
  int cyc = 0;
  bit mon_on = 0, rnd = 0, hold = 0, inject = 0;
  // burst-level reference state
  int ack_cyc = -1, idle_from = 0, cur_len = 0, issued = 0, mout = 0, acc_cnt = 0;
  int zero_done_cyc = -1;
  bit zero_owner = 0, last_wt = 1, err_model = 0;

  function automatic logic [127:0] data_of(input logic [15:0] a);
    return {4{a, ~a}};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  always @(posedge clk) cyc++;

  // memory: in-order returns, earliest one cycle after accept
  always @(posedge clk) begin
    #1;
    mem_rd_valid = 1'b0;
    if (inject) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = {$urandom, $urandom, $urandom, $urandom};
      inject       = 1'b0;
    end else if (!hold && pend.size() > 0 && pend[0].rdy <= cyc && (!rnd || $urandom_range(3) != 0)) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = data_of(pend[0].addr);
      void'(pend.pop_front());
    end
    mem_rd_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (mon_on) begin
      bit    in_burst, exp_fd, exp_wd;
      beat_t b;
      logic [15:0] ad;
      in_burst = (cyc > ack_cyc) && (cyc < idle_from);
      chk("busy", busy, in_burst);
      chk("mem_rd_req", mem_rd_req, in_burst && (issued < cur_len) && (mout < MAX_OUT));
      chk("protocol_err", protocol_err, err_model);
      chk("double_ack", feat_ack && wt_ack, 1'b0);
      if (cyc >= idle_from && (feat_req || wt_req)) chk("ack_when_idle", feat_ack || wt_ack, 1'b1);
      if (feat_ack || wt_ack) begin
        chk("ack_while_busy", cyc >= idle_from, 1'b1);
        chk("arb_winner", wt_ack, (feat_req && wt_req) ? !last_wt : wt_req);
      end

      exp_fd = (cyc == zero_done_cyc) && !zero_owner;
      exp_wd = (cyc == zero_done_cyc) && zero_owner;
      if (feature_fetch_enable || weight_fetch_enable) begin
        chk("dual_enable", feature_fetch_enable && weight_fetch_enable, 1'b0);
        if (exp_q.size() == 0) fail_now("spurious_enable");
        else begin
          b = exp_q.pop_front();
          chk("beat_owner", weight_fetch_enable, b.wt);
          chk("beat_data", fetch_data, b.data);
          if (b.last) begin
            exp_fd    = !b.wt;
            exp_wd    = b.wt;
            idle_from = cyc + 1;
          end
        end
      end
      chk("done", {feat_done, wt_done}, {exp_fd, exp_wd});

      if (mem_rd_req && mem_rd_ready) begin
        if (exp_addr_q.size() == 0) fail_now("unexpected_rd_req");
        else begin
          ad = exp_addr_q.pop_front();
          chk("rd_addr", mem_rd_addr, ad);
        end
        pend.push_back('{mem_rd_addr, cyc + 1});
        issued++;
        mout++;
        acc_cnt++;
      end
      if (mem_rd_valid) begin
        if (mout == 0) err_model = 1'b1;
        else mout--;
      end

      if (feat_ack || wt_ack) begin
        bit          w;
        logic [15:0] base;
        int          len;
        w       = wt_ack;
        base    = w ? wt_src_addr : feat_src_addr;
        len     = int'(w ? wt_len : feat_len);
        ack_cyc = cyc;
        cur_len = len;
        issued  = 0;
        acc_cnt = 0;
        last_wt = w;
        for (int i = 0; i < len; i++) begin
          ad = base + 16'(i);
          exp_addr_q.push_back(ad);
          exp_q.push_back('{w, data_of(ad), i == len - 1});
        end
        idle_from     = (len == 0) ? cyc + 2 : 32'h7fffffff;
        zero_done_cyc = (len == 0) ? cyc + 2 : -1;
        zero_owner    = w;
      end
    end
  end

  task automatic burst(input bit w, input logic [15:0] a, input logic [7:0] l);
    int n = 0;
    @(posedge clk); #1;
    if (w) begin wt_req = 1'b1; wt_src_addr = a; wt_len = l; end
    else begin feat_req = 1'b1; feat_src_addr = a; feat_len = l; end
    do begin
      @(negedge clk);
      n++;
    end while (!(w ? wt_ack : feat_ack) && n < 1000);
    if (n >= 1000) fail_now(w ? "wt_ack_timeout" : "feat_ack_timeout");
    @(posedge clk); #1;
    if (w) wt_req = 1'b0; else feat_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || cyc < idle_from) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) fail_now("drain_timeout");
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    feat_req = 1'b0; wt_req = 1'b0;
    feat_src_addr = '0; wt_src_addr = '0; feat_len = '0; wt_len = '0;
    mem_rd_ready = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {feat_ack, feat_done, wt_ack, wt_done, mem_rd_req, mem_rd_addr,
                       fetch_data, feature_fetch_enable, weight_fetch_enable, busy, protocol_err}, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    mon_on = 1'b1;

    // contested grants: feature first after reset, then alternation by rule
    fork
      burst(1'b0, 16'h0300, 8'd2);
      burst(1'b1, 16'h0400, 8'd2);
    join
    drain();
    fork
      burst(1'b0, 16'h0500, 8'd1);
      burst(1'b1, 16'h0600, 8'd1);
    join
    drain();

    burst(1'b0, 16'h0100, 8'd3);
    drain();

    // memory stalls: in-flight cap
    hold = 1'b1;
    burst(1'b1, 16'h2000, 8'd8);
    repeat (10) @(negedge clk);
    chk("max_out_accepts", acc_cnt, MAX_OUT);
    hold = 1'b0;
    drain();

    burst(1'b0, 16'hFFFE, 8'd4);
    drain();
    burst(1'b1, 16'h1234, 8'd0);
    drain();

    @(negedge clk);
    inject = 1'b1;
    repeat (3) @(negedge clk);

    rnd = 1'b1;
    for (int it = 0; it < 40; it++) begin
      bit          df, dw;
      logic [15:0] af, aw;
      df = $urandom_range(1) != 0;
      dw = $urandom_range(1) != 0;
      if (!df && !dw) df = 1'b1;
      af = ($urandom_range(3) == 0) ? 16'hFFF8 + 16'($urandom_range(7)) : 16'($urandom);
      aw = ($urandom_range(3) == 0) ? 16'hFFF8 + 16'($urandom_range(7)) : 16'($urandom);
      fork
        if (df) burst(1'b0, af, 8'($urandom_range(12)));
        if (dw) burst(1'b1, aw, 8'($urandom_range(12)));
      join
      drain();
    end
    burst(1'b1, 16'h7000, 8'd255);
    drain();

    // reset mid-burst with a request still pending
    burst(1'b0, 16'h4000, 8'd20);
    repeat (8) @(negedge clk);
    mon_on = 1'b0;
    feat_req = 1'b1;
    @(posedge clk); #3;
    rst = 1'b0;
    @(negedge clk);
    chk("midburst_reset_outs", {feat_ack, feat_done, wt_ack, wt_done, mem_rd_req, mem_rd_addr,
                                fetch_data, feature_fetch_enable, weight_fetch_enable, busy, protocol_err}, '0);
    @(negedge clk);
    chk("reset_hold_outs", {feat_ack, mem_rd_req, feature_fetch_enable, busy, protocol_err}, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
